// File: rtl/exec_stage.sv
// exec_stage: multicycle execute stage wrapped around an 8x16 register file.
// On start it reads rn then rm through the file's read port, shifts operand B,
// runs one of ADD/CMP/AND/MVN, latches result and {N,V,Z} flags and (except
// for CMP) writes the result back through the file's write port.
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   start, op, shift     - request and operation fields (sampled in IDLE only)
//   rn, rm, rd           - source A, source B, destination register numbers
//   rf_data_out          - register file read data (combinational on readnum)
//   readnum              - register file read select
//   writenum, write      - register file write select and write enable
//   rf_data_in           - register file write data
//   c_out, status        - latched result and {N,V,Z} flags
//   busy, done           - not-idle indicator and one-cycle completion pulse
// Every output is a flop, so there is no combinational input-to-output path.
module exec_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [1:0]   shift,
    input  logic [2:0]   rn,
    input  logic [2:0]   rm,
    input  logic [2:0]   rd,
    input  logic [W-1:0] rf_data_out,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic [W-1:0] rf_data_in,
    output logic [W-1:0] c_out,
    output logic [2:0]   status,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [1:0]   shift_q, shift_d;
    logic [2:0]   rn_q, rn_d;
    logic [2:0]   rm_q, rm_d;
    logic [2:0]   rd_q, rd_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_out_q, c_out_d;
    logic [2:0]   status_q, status_d;
    logic [2:0]   readnum_q, readnum_d;
    logic [2:0]   writenum_q, writenum_d;
    logic         write_q, write_d;
    logic [W-1:0] rf_data_in_q, rf_data_in_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W-1:0] alu_res_s;
    logic         alu_v_s;

    // Operand B pre-shift: LSL1, LSR1 (zero fill) or ASR1 (sign fill).
    function automatic logic [W-1:0] shift_b(input logic [W-1:0] v, input logic [1:0] s);
        logic [W-1:0] r;
        case (s)
            2'b00:   r = v;
            2'b01:   r = {v[W-2:0], 1'b0};
            2'b10:   r = {1'b0, v[W-1:1]};
            2'b11:   r = {v[W-1], v[W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // ALU on the captured operands; V is signed overflow for ADD/CMP only.
    always_comb begin
        alu_res_s = {W{1'b0}};
        alu_v_s   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_s = a_q + b_q;
                alu_v_s   = (a_q[W-1] == b_q[W-1]) && (alu_res_s[W-1] != a_q[W-1]);
            end
            OP_CMP: begin
                alu_res_s = a_q - b_q;
                alu_v_s   = (a_q[W-1] != b_q[W-1]) && (alu_res_s[W-1] != a_q[W-1]);
            end
            OP_AND: begin
                alu_res_s = a_q & b_q;
                alu_v_s   = 1'b0;
            end
            OP_MVN: begin
                alu_res_s = ~b_q;
                alu_v_s   = 1'b0;
            end
            default: begin
                alu_res_s = {W{1'b0}};
                alu_v_s   = 1'b0;
            end
        endcase
    end

    // Next-state and next-output decode; outputs are computed from the state
    // being entered so that they are valid for the whole of that state.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        shift_d      = shift_q;
        rn_d         = rn_q;
        rm_d         = rm_q;
        rd_d         = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        c_out_d      = c_out_q;
        status_d     = status_q;
        readnum_d    = 3'd0;
        writenum_d   = 3'd0;
        write_d      = 1'b0;
        rf_data_in_d = {W{1'b0}};
        busy_d       = 1'b1;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    shift_d = shift;
                    rn_d    = rn;
                    rm_d    = rm;
                    rd_d    = rd;
                    state_d = LOAD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A: begin
                a_d     = rf_data_out;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                b_d     = shift_b(rf_data_out, shift_q);
                state_d = EXEC;
            end
            EXEC: begin
                c_out_d  = alu_res_s;
                status_d = {alu_res_s[W-1], alu_v_s, (alu_res_s == {W{1'b0}})};
                if (op_q == OP_CMP) begin
                    state_d = DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:   busy_d = 1'b0;
            LOAD_A: readnum_d = rn_d;
            LOAD_B: readnum_d = rm_d;
            EXEC:   busy_d = 1'b1;
            WRITE: begin
                write_d      = 1'b1;
                writenum_d   = rd_q;
                rf_data_in_d = c_out_d;
            end
            DONE:    done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State, latched fields, operands and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= 2'd0;
            shift_q      <= 2'd0;
            rn_q         <= 3'd0;
            rm_q         <= 3'd0;
            rd_q         <= 3'd0;
            a_q          <= {W{1'b0}};
            b_q          <= {W{1'b0}};
            c_out_q      <= {W{1'b0}};
            status_q     <= 3'd0;
            readnum_q    <= 3'd0;
            writenum_q   <= 3'd0;
            write_q      <= 1'b0;
            rf_data_in_q <= {W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            shift_q      <= shift_d;
            rn_q         <= rn_d;
            rm_q         <= rm_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_out_q      <= c_out_d;
            status_q     <= status_d;
            readnum_q    <= readnum_d;
            writenum_q   <= writenum_d;
            write_q      <= write_d;
            rf_data_in_q <= rf_data_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign readnum    = readnum_q;
    assign writenum   = writenum_q;
    assign write      = write_q;
    assign rf_data_in = rf_data_in_q;
    assign c_out      = c_out_q;
    assign status     = status_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [2:0]  rd;
    logic [15:0] rf_data_out;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] rf_data_in;
    logic [15:0] c_out;
    logic [2:0]  status;
    logic        busy;
    logic        done;

    // register file model with a bench-side preload port
    logic [15:0] rf [8];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    int total_cnt;
    int bad_cnt;

    exec_stage #(.W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
        .rn(rn), .rm(rm), .rd(rd), .rf_data_out(rf_data_out),
        .readnum(readnum), .writenum(writenum), .write(write),
        .rf_data_in(rf_data_in), .c_out(c_out), .status(status),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_data_out = rf[readnum];

    always @(posedge clk) begin
        if (write) begin
            rf[writenum] <= rf_data_in;
        end else if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issue one operation and watch 10 cycles after the sampling edge k.
    // Cycle index i means "sampled #1 after edge k+i".
    task automatic run_op(input logic [1:0] o, input logic [1:0] s,
                          input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                          input int poke_at,
                          output int done_cyc, output int dn_cnt, output int wr_cnt,
                          output int busy_fall, output logic busy0,
                          output logic [2:0] wn, output logic [15:0] wd);
        @(negedge clk);
        op = o; shift = s; rn = a; rm = b; rd = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy;
        done_cyc = -1; dn_cnt = 0; wr_cnt = 0; busy_fall = -1;
        wn = 3'd0; wd = 16'd0;
        for (int i = 1; i <= 10; i++) begin
            if (i == poke_at) begin
                start = 1'b1;
                op = 2'b00; rn = 3'd7; rm = 3'd7; rd = 3'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (write) begin
                wr_cnt++;
                wn = writenum;
                wd = rf_data_in;
            end
            if (done) begin
                dn_cnt++;
                if (done_cyc < 0) done_cyc = i;
            end
            if (!busy && busy_fall < 0) busy_fall = i;
        end
        start = 1'b0;
    endtask

    int          dcyc, dcnt, wcnt, bfall;
    logic        b0;
    logic [2:0]  wn;
    logic [15:0] wd;
    int          wr_in_reset;

    initial begin
        total_cnt = 0; bad_cnt = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; shift = 2'b00;
        rn = 3'd0; rm = 3'd0; rd = 3'd0;
        pre_we = 1'b0; pre_addr = 3'd0; pre_data = 16'd0;
        for (int j = 0; j < 8; j++) rf[j] = 16'd0;
        #2;
        check_val("rst_busy",   {31'd0, busy}, 32'd0);
        check_val("rst_done",   {31'd0, done}, 32'd0);
        check_val("rst_write",  {31'd0, write}, 32'd0);
        check_val("rst_cout",   {16'd0, c_out}, 32'd0);
        check_val("rst_status", {29'd0, status}, 32'd0);
        check_val("rst_readnum", {29'd0, readnum}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ADD R3 = R1 + R2 = 3 + 4
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0004);
        preload(3'd7, 16'hBEEF);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("add_busy0", {31'd0, b0}, 32'd1);
        check_val("add_done_cyc", dcyc, 32'd4);
        check_val("add_done_cnt", dcnt, 32'd1);
        check_val("add_wr_cnt", wcnt, 32'd1);
        check_val("add_wn", {29'd0, wn}, 32'd3);
        check_val("add_wd", {16'd0, wd}, 32'h0007);
        check_val("add_busy_fall", bfall, 32'd5);
        check_val("add_rf3", {16'd0, rf[3]}, 32'h0007);
        check_val("add_cout", {16'd0, c_out}, 32'h0007);
        check_val("add_status", {29'd0, status}, 32'd0);

        // ADD overflow: 0x7FFF + 1 -> 0x8000, N=1 V=1 Z=0
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("ovf_rf4", {16'd0, rf[4]}, 32'h8000);
        check_val("ovf_cout", {16'd0, c_out}, 32'h8000);
        check_val("ovf_status", {29'd0, status}, 32'b110);

        // CMP equal operands: no writeback, Z=1, done one cycle earlier
        preload(3'd5, 16'h1234);
        preload(3'd6, 16'h1234);
        run_op(2'b01, 2'b00, 3'd5, 3'd6, 3'd7, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("cmp_done_cyc", dcyc, 32'd3);
        check_val("cmp_wr_cnt", wcnt, 32'd0);
        check_val("cmp_busy_fall", bfall, 32'd4);
        check_val("cmp_status", {29'd0, status}, 32'b001);
        check_val("cmp_cout", {16'd0, c_out}, 32'd0);
        check_val("cmp_rf7", {16'd0, rf[7]}, 32'hBEEF);
        check_val("cmp_rf5", {16'd0, rf[5]}, 32'h1234);

        // MVN with ASR1: ~(0x8001 >>> 1) = ~0xC000 = 0x3FFF into R1
        preload(3'd1, 16'h8001);
        run_op(2'b11, 2'b11, 3'd0, 3'd1, 3'd1, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("mvn_asr_rf1", {16'd0, rf[1]}, 32'h3FFF);
        check_val("mvn_asr_status", {29'd0, status}, 32'b000);

        // ADD with LSR1: R4(0x8000) + (R3(7) >> 1 = 3) = 0x8003, N=1 V=0
        run_op(2'b00, 2'b10, 3'd4, 3'd3, 3'd5, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("add_lsr_rf5", {16'd0, rf[5]}, 32'h8003);
        check_val("add_lsr_status", {29'd0, status}, 32'b100);

        // MVN with LSL1: ~(7 << 1) = ~0x000E = 0xFFF1 into R6
        run_op(2'b11, 2'b01, 3'd0, 3'd3, 3'd6, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("mvn_lsl_rf6", {16'd0, rf[6]}, 32'hFFF1);
        check_val("mvn_lsl_status", {29'd0, status}, 32'b100);

        // AND R2 = R2 & R2 (R2 = 1), start poked while busy must be ignored
        run_op(2'b10, 2'b00, 3'd2, 3'd2, 3'd2, 2, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("and_rf2", {16'd0, rf[2]}, 32'h0001);
        check_val("and_done_cnt", dcnt, 32'd1);
        check_val("and_wr_cnt", wcnt, 32'd1);
        check_val("and_rf7_untouched", {16'd0, rf[7]}, 32'hBEEF);

        // Reset during EXEC aborts with no write and no done
        @(negedge clk);
        op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd0;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_cout", {16'd0, c_out}, 32'd0);
        check_val("mid_rst_status", {29'd0, status}, 32'd0);
        check_val("mid_rst_readnum", {29'd0, readnum}, 32'd0);
        wr_in_reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (write || done) wr_in_reset++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (write || done || busy) wr_in_reset++;
        end
        check_val("rst_abort_quiet", wr_in_reset, 32'd0);
        check_val("rst_abort_rf0", {16'd0, rf[0]}, 32'd0);

        // Fresh ADD after reset: R1(0x3FFF) + R2(1) = 0x4000 into R0
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd0, 0, dcyc, dcnt, wcnt, bfall, b0, wn, wd);
        check_val("post_rst_done_cyc", dcyc, 32'd4);
        check_val("post_rst_rf0", {16'd0, rf[0]}, 32'h4000);
        check_val("post_rst_status", {29'd0, status}, 32'b000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
